// File: rtl/filter_test_harness.sv
// Stimulus source, reset generator and output sink for the 12-bit IIR filter.
// The source drives a sawtooth with optional idle gaps; the sink keeps running statistics until end_sim.
module filter_test_harness #(
    parameter int NB        = 12,
    parameter int N_SAMPLES = 64,
    parameter int STEP      = 64,
    parameter int GAP       = 0,
    parameter int RST_HOLD  = 4,
    parameter int DRAIN     = 10,
    parameter int B0        = 212,
    parameter int B1        = 424,
    parameter int B2        = 212,
    parameter int A1        = -1366,
    parameter int A2        = 426
) (
    input  logic              clock,
    input  logic              reset,
    output logic              rst_n_o,
    output logic              vOut,
    output logic [NB-1:0]     dOut,
    output logic [3*NB-1:0]   b,
    output logic [2*NB-1:0]   a,
    input  logic              vIn,
    input  logic [NB-1:0]     dIn,
    output logic              end_sim,
    output logic [15:0]       out_count,
    output logic [23:0]       out_sum,
    output logic [NB-1:0]     last_out
);

    typedef enum logic [2:0] {S_HOLD, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

    localparam logic [31:0]   HOLD_LAST  = 32'(RST_HOLD - 1);
    localparam logic [31:0]   GAP_LAST   = 32'(GAP - 1);
    localparam logic [31:0]   DRAIN_LAST = 32'(DRAIN);
    localparam logic [15:0]   K_LAST     = 16'(N_SAMPLES - 1);
    localparam logic [NB-1:0] STEP_W     = NB'(STEP);

    state_t          r_state, w_state_nxt;
    logic [31:0]     r_cnt, w_cnt_nxt;
    logic [15:0]     r_k, w_k_nxt;
    logic [NB-1:0]   r_acc, w_acc_nxt;
    logic [NB-1:0]   r_dout, w_dout_nxt;
    logic            r_vout, w_vout_nxt;
    logic            r_rstn, w_rstn_nxt;
    logic            r_end, w_end_nxt;
    logic [15:0]     r_count;
    logic [23:0]     r_sum;
    logic [NB-1:0]   r_last;
    logic            w_capture;

    assign b = {NB'(B2), NB'(B1), NB'(B0)};
    assign a = {NB'(A2), NB'(A1)};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_dout  <= '0;
            r_vout  <= 1'b0;
            r_rstn  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_k     <= w_k_nxt;
            r_acc   <= w_acc_nxt;
            r_dout  <= w_dout_nxt;
            r_vout  <= w_vout_nxt;
            r_rstn  <= w_rstn_nxt;
            r_end   <= w_end_nxt;
        end
    end

    // DRAIN compares against DRAIN (not DRAIN-1) so end_sim lands DRAIN+1 edges after the last sample
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (r_k == K_LAST) w_state_nxt = S_DRAIN;
                else if (GAP > 0)  w_state_nxt = S_GAP;
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_state_nxt = S_DONE;
                else                     w_cnt_nxt   = r_cnt + 32'd1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_rstn_nxt = r_rstn;
        w_vout_nxt = 1'b0;
        w_dout_nxt = r_dout;
        w_acc_nxt  = r_acc;
        w_k_nxt    = r_k;
        w_end_nxt  = r_end;
        case (r_state)
            S_HOLD:  if (r_cnt == HOLD_LAST) w_rstn_nxt = 1'b1;
            S_RUN: begin
                w_vout_nxt = 1'b1;
                w_dout_nxt = r_acc;
                w_acc_nxt  = r_acc + STEP_W;
                w_k_nxt    = r_k + 16'd1;
            end
            S_DRAIN: if (r_cnt == DRAIN_LAST) w_end_nxt = 1'b1;
            default: ;
        endcase
    end

    assign w_capture = vIn & r_rstn & ~r_end;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_sum   <= '0;
            r_last  <= '0;
        end else if (w_capture) begin
            r_count <= r_count + 16'd1;
            r_sum   <= r_sum + {{(24-NB){dIn[NB-1]}}, dIn};
            r_last  <= dIn;
        end
    end

    assign rst_n_o   = r_rstn;
    assign vOut      = r_vout;
    assign dOut      = r_dout;
    assign end_sim   = r_end;
    assign out_count = r_count;
    assign out_sum   = r_sum;
    assign last_out  = r_last;

endmodule

// File: tb/tb_filter_test_harness.sv
// Scoreboard bench for filter_test_harness: default, gapped and long wrap-around configurations.
module tb_filter_test_harness;

    typedef struct {
        int         ed;
        logic [11:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    logic vIn0 = 1'b0;
    logic [11:0] dIn0 = '0;
    logic vIn1 = 1'b0;
    logic [11:0] dIn1 = '0;
    logic [11:0] dIn2 = 12'h001;

    logic rstn0, v0, end0, rstn1, v1, end1, rstn2, v2, end2;
    logic [11:0] d0, d1, d2, last0, last1, last2;
    logic [35:0] b0, b1, b2;
    logic [23:0] a0, a1, a2, sum0, sum1, sum2;
    logic [15:0] cnt0, cnt1, cnt2;

    int n_cmp = 0;
    int n_bad = 0;
    int e_n = 0;
    int e2 = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t x0, x1;

    always #5 clk = ~clk;

    filter_test_harness dut0 (
        .clock(clk), .reset(rst), .rst_n_o(rstn0), .vOut(v0), .dOut(d0), .b(b0), .a(a0),
        .vIn(vIn0), .dIn(dIn0), .end_sim(end0), .out_count(cnt0), .out_sum(sum0), .last_out(last0)
    );

    filter_test_harness #(.N_SAMPLES(4), .GAP(2)) dut1 (
        .clock(clk), .reset(rst), .rst_n_o(rstn1), .vOut(v1), .dOut(d1), .b(b1), .a(a1),
        .vIn(vIn1), .dIn(dIn1), .end_sim(end1), .out_count(cnt1), .out_sum(sum1), .last_out(last1)
    );

    filter_test_harness #(.N_SAMPLES(65535)) dut2 (
        .clock(clk), .reset(rst2), .rst_n_o(rstn2), .vOut(v2), .dOut(d2), .b(b2), .a(a2),
        .vIn(rstn2), .dIn(dIn2), .end_sim(end2), .out_count(cnt2), .out_sum(sum2), .last_out(last2)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) e_n <= 0;
        else     e_n <= e_n + 1;
    end

    always @(posedge clk or posedge rst2) begin
        if (rst2) e2 <= 0;
        else      e2 <= e2 + 1;
    end

    task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_e(input int n);
        while (e_n < n) @(negedge clk);
    endtask

    task automatic wait_e2(input int n);
        while (e2 < n) @(negedge clk);
    endtask

    task automatic push0(input int n);
        for (int k = 0; k < n; k++) q0.push_back('{ed: 5 + k, dat: 12'(k * 64)});
    endtask

    task automatic push1();
        q1.push_back('{ed: 5,  dat: 12'h000});
        q1.push_back('{ed: 8,  dat: 12'h040});
        q1.push_back('{ed: 11, dat: 12'h080});
        q1.push_back('{ed: 14, dat: 12'h0C0});
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, " rst_n_o"}, 40'(rstn0), 40'h0);
        chk({tag, " vOut"}, 40'(v0), 40'h0);
        chk({tag, " dOut"}, 40'(d0), 40'h0);
        chk({tag, " end_sim"}, 40'(end0), 40'h0);
        chk({tag, " out_count"}, 40'(cnt0), 40'h0);
        chk({tag, " out_sum"}, 40'(sum0), 40'h0);
        chk({tag, " last_out"}, 40'(last0), 40'h0);
    endtask

    // Monitor: every vOut pulse must match the head of its expectation queue
    always @(negedge clk) begin
        if (!rst) begin
            if (v0) begin
                if (q0.size() == 0) chk("dut0 unexpected vOut", 40'h1, 40'h0);
                else begin
                    x0 = q0.pop_front();
                    chk("dut0 sample edge", 40'(e_n), 40'(x0.ed));
                    chk("dut0 sample data", 40'(d0), 40'(x0.dat));
                end
            end
            if (v1) begin
                if (q1.size() == 0) chk("dut1 unexpected vOut", 40'h1, 40'h0);
                else begin
                    x1 = q1.pop_front();
                    chk("dut1 sample edge", 40'(e_n), 40'(x1.ed));
                    chk("dut1 sample data", 40'(d1), 40'(x1.dat));
                end
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_zero0("reset");
        chk("b coeffs", 40'(b0), 40'h0D41A80D4);
        chk("a coeffs", 40'(a0), 40'h1AAAAA);

        push0(64);
        push1();
        rst = 1'b0;
        rst2 = 1'b0;

        wait_e(3);
        chk("rst_n_o at E3", 40'(rstn0), 40'h0);
        chk("vOut at E3", 40'(v0), 40'h0);
        wait_e(4);
        chk("rst_n_o at E4", 40'(rstn0), 40'h1);
        chk("vOut at E4", 40'(v0), 40'h0);
        wait_e(6);
        chk("dOut at E6", 40'(d0), 40'h040);

        wait_e(9);
        vIn0 = 1'b1; dIn0 = 12'h7FF;
        wait_e(10);
        dIn0 = 12'h001;
        wait_e(11);
        dIn0 = 12'h800;
        wait_e(12);
        vIn0 = 1'b0;
        chk("sink out_count", 40'(cnt0), 40'd3);
        chk("sink out_sum", 40'(sum0), 40'h000000);
        chk("sink last_out", 40'(last0), 40'h800);

        wait_e(24);
        chk("dut1 end_sim at E24", 40'(end1), 40'h0);
        wait_e(25);
        chk("dut1 end_sim at E25", 40'(end1), 40'h1);
        wait_e(37);
        chk("dOut at E37", 40'(d0), 40'h800);

        wait_e(78);
        chk("end_sim at E78", 40'(end0), 40'h0);
        vIn0 = 1'b1; dIn0 = 12'h005;
        wait_e(79);
        vIn0 = 1'b0;
        chk("end_sim at E79", 40'(end0), 40'h1);
        chk("coincident out_count", 40'(cnt0), 40'd4);
        chk("coincident out_sum", 40'(sum0), 40'h000005);
        chk("coincident last_out", 40'(last0), 40'h005);
        wait_e(80);
        chk("dOut held after run", 40'(d0), 40'hFC0);
        wait_e(81);
        vIn0 = 1'b1; dIn0 = 12'h123;
        wait_e(82);
        vIn0 = 1'b0;
        chk("frozen out_count", 40'(cnt0), 40'd4);
        chk("frozen out_sum", 40'(sum0), 40'h000005);
        chk("frozen last_out", 40'(last0), 40'h005);
        chk("end_sim sticky", 40'(end0), 40'h1);
        chk("dut0 queue drained", 40'(q0.size()), 40'h0);

        #2 rst = 1'b1;
        #1 chk_zero0("reset in DONE");
        chk("dut1 end_sim reset", 40'(end1), 40'h0);

        @(negedge clk);
        push0(11);
        push1();
        rst = 1'b0;
        wait_e(15);
        #2 rst = 1'b1;
        #1 chk_zero0("mid-run reset");
        chk("mid-run dut0 queue", 40'(q0.size()), 40'h0);
        chk("mid-run dut1 queue", 40'(q1.size()), 40'h0);

        @(negedge clk);
        push0(64);
        push1();
        rst = 1'b0;
        wait_e(4);
        chk("restart vOut at E4", 40'(v0), 40'h0);
        wait_e(6);
        chk("restart dOut at E6", 40'(d0), 40'h040);
        wait_e(80);
        chk("restart end_sim", 40'(end0), 40'h1);
        chk("restart dut0 queue", 40'(q0.size()), 40'h0);
        chk("restart dut1 queue", 40'(q1.size()), 40'h0);

        wait_e2(65540);
        chk("wrap out_count", 40'(cnt2), 40'h0);
        chk("wrap out_sum", 40'(sum2), 40'h010000);
        wait_e2(65549);
        chk("wrap end_sim early", 40'(end2), 40'h0);
        chk("wrap count E65549", 40'(cnt2), 40'd9);
        wait_e2(65550);
        chk("wrap end_sim", 40'(end2), 40'h1);
        chk("wrap final count", 40'(cnt2), 40'd10);
        chk("wrap final sum", 40'(sum2), 40'h01000A);
        wait_e2(65553);
        chk("wrap frozen count", 40'(cnt2), 40'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
